plot_receiver: RTL

- Receiving end of the pixel-plot interface (x, y, colour, plot) that the drawing FSMs drive.
- Accepts one plot request per cycle, clips it to the 160x120 screen and buffers it in a small FIFO.
- Drains the FIFO into a linear framebuffer write port using a valid/ready handshake.
- Also performs a full-screen clear to a background colour on request. Sits between the game drawing logic and the framebuffer memory.

---
 rtl/plot_receiver_if.sv | 24 ++
 rtl/plot_receiver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/plot_receiver_if.sv
// Pixel-plot request bus (drawing FSM -> receiver) and framebuffer write port (receiver -> memory).
// Widths are fixed by the 160x120 screen: 8-bit x, 7-bit y, 3-bit colour, 15-bit linear address.
interface plot_if;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       clear;
  logic [2:0] bg_colour;
  logic       busy;

  modport master (output plot, x, y, colour, clear, bg_colour, input busy);
  modport slave  (input plot, x, y, colour, clear, bg_colour, output busy);
endinterface

interface fb_if;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_wren;
  logic        mem_ready;

  modport master (output mem_addr, mem_data, mem_wren, input mem_ready);
  modport slave  (input mem_addr, mem_data, mem_wren, output mem_ready);
endinterface

// File: rtl/plot_receiver.sv
// Clips plot requests to the screen, queues them and drains them to the framebuffer; also fills the screen on clear.
// Latency: plot in cycle 0 -> mem_wren in cycle 2. Backpressure: busy while FIFO full or clearing; plots then are dropped.
module plot_receiver #(
  parameter int DEPTH    = 8,
  parameter int PTR_W    = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        resetn,
  plot_if.slave       req,
  fb_if.master        fb,
  output logic        clear_done,
  output logic [15:0] dropped_count,
  output logic [15:0] clipped_count
);

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  colour;
  } pix_t;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  localparam logic [14:0]  LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  state_t           state;
  pix_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             clr_pend;
  logic [2:0]       clr_colour;
  logic             out_vld;
  logic [14:0]      out_addr;
  logic [2:0]       out_data;

  logic       full, empty, busy, in_range;
  logic       drop, clip, push, pop, flush;
  logic       hs, out_free, clr_req;
  logic [2:0] clr_pick;
  pix_t       pix;

  assign full     = (fifo_cnt == FULL_CNT);
  assign empty    = (fifo_cnt == '0);
  assign busy     = full || (state == CLEAR);
  assign in_range = (req.x < 8'(SCREEN_W)) && (req.y < 7'(SCREEN_H));

  // A clear arriving in IDLE takes priority over a simultaneous plot.
  assign drop = req.plot && (busy || (state == IDLE && req.clear));
  assign clip = req.plot && !drop && !in_range;
  assign push = req.plot && !drop && in_range;

  assign pix.addr   = 15'(req.y) * 15'(SCREEN_W) + 15'(req.x);
  assign pix.colour = req.colour;

  assign hs       = out_vld && fb.mem_ready;
  assign out_free = !out_vld || hs;
  assign clr_req  = clr_pend || req.clear;
  assign clr_pick = clr_pend ? clr_colour : req.bg_colour;
  assign flush    = (state == DRAIN) && out_free && clr_req;
  assign pop      = (state == DRAIN) && out_free && !clr_req && !empty;

  assign req.busy    = busy;
  assign fb.mem_addr = out_addr;
  assign fb.mem_data = out_data;
  assign fb.mem_wren = out_vld;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pix;
  end

  // Flushing on a pending clear discards anything still queued, including a same-cycle push.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      out_vld    <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      clr_pend   <= 1'b0;
      clr_colour <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req.clear) begin
            state    <= CLEAR;
            out_vld  <= 1'b1;
            out_addr <= '0;
            out_data <= req.bg_colour;
          end else if (push) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (req.clear && !clr_pend) begin
            clr_pend   <= 1'b1;
            clr_colour <= req.bg_colour;
          end
          if (out_free) begin
            if (clr_req) begin
              state    <= CLEAR;
              clr_pend <= 1'b0;
              out_vld  <= 1'b1;
              out_addr <= '0;
              out_data <= clr_pick;
            end else if (!empty) begin
              out_vld  <= 1'b1;
              out_addr <= fifo_mem[rd_ptr].addr;
              out_data <= fifo_mem[rd_ptr].colour;
            end else begin
              out_vld <= 1'b0;
              if (!push) state <= IDLE;
            end
          end
        end
        CLEAR: begin
          if (hs) begin
            if (out_addr == LAST_ADDR) begin
              state      <= IDLE;
              out_vld    <= 1'b0;
              out_addr   <= '0;
              out_data   <= '0;
              clear_done <= 1'b1;
            end else begin
              out_addr <= out_addr + 15'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dropped_count <= '0;
      clipped_count <= '0;
    end else begin
      if (drop && dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
      if (clip && clipped_count != 16'hFFFF) clipped_count <= clipped_count + 16'd1;
    end
  end

endmodule
